// File: rtl/count_param.sv
// Parameterised up/down counter with an inclusive runtime bound, wrap or saturate modes and a boundary pulse.
// Optional sticky ovf/unf flags are enabled by defining COUNT_PARAM_STICKY_FLAGS_EN.
module count_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              up_down,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [WIDTH-1:0]  cin,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  cout,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  typedef logic [WIDTH:0] ext_t;

  localparam ext_t ONE = ext_t'(1);

  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] eff_step;
  logic [WIDTH-1:0] cout_nxt;
  ext_t             cout_x;
  ext_t             max_x;
  ext_t             step_x;
  ext_t             sum_up;
  ext_t             wrap_up;
  ext_t             wrap_dn;
  logic             tc_nxt;
  logic             ovf_set;
  logic             unf_set;

  // All arithmetic is one bit wider than the count so sums past 2**WIDTH-1 never truncate.
  always_comb begin
    step_w   = WIDTH'(step);
    eff_step = (step_w > max_val) ? max_val : step_w;
    cout_x   = {1'b0, cout};
    max_x    = {1'b0, max_val};
    step_x   = {1'b0, eff_step};
    sum_up   = cout_x + step_x;
    wrap_up  = sum_up - (max_x + ONE);
    wrap_dn  = cout_x + max_x + ONE - step_x;
  end

  always_comb begin
    cout_nxt = cout;
    tc_nxt   = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (en) begin
      if (load) begin
        cout_nxt = (cin > max_val) ? max_val : cin;
      end else if (max_val == '0) begin
        cout_nxt = '0;
      end else if (eff_step == '0) begin
        cout_nxt = cout;
      end else if (cout_x > max_x) begin
        // Bound was lowered below the current count: clamp regardless of direction or mode.
        cout_nxt = max_val;
        tc_nxt   = 1'b1;
        ovf_set  = 1'b1;
      end else if (up_down) begin
        if (sum_up > max_x) begin
          cout_nxt = sat ? max_val : wrap_up[WIDTH-1:0];
          tc_nxt   = 1'b1;
          ovf_set  = 1'b1;
        end else begin
          cout_nxt = sum_up[WIDTH-1:0];
        end
      end else begin
        if (step_x > cout_x) begin
          cout_nxt = sat ? '0 : wrap_dn[WIDTH-1:0];
          tc_nxt   = 1'b1;
          unf_set  = 1'b1;
        end else begin
          cout_nxt = cout - eff_step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= '0;
      tc   <= 1'b0;
    end else begin
      cout <= cout_nxt;
      tc   <= tc_nxt;
    end
  end

`ifdef COUNT_PARAM_STICKY_FLAGS_EN
  // A set event in the same cycle beats clr_flags; clearing works even with en low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)        ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (unf_set)        unf <= 1'b1;
      else if (clr_flags) unf <= 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{clr_flags, ovf_set, unf_set};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_count_param.sv
// Directed self-checking bench for count_param (WIDTH=8, STEP_W=4).
// Flag expectations follow whether COUNT_PARAM_STICKY_FLAGS_EN is defined for the build.
module tb_count_param;

`ifdef COUNT_PARAM_STICKY_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load, up_down, sat, clr_flags;
  logic [3:0] step;
  logic [7:0] max_val, cin;
  logic [7:0] cout;
  logic       tc, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  count_param #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down), .sat(sat),
    .step(step), .max_val(max_val), .cin(cin), .clr_flags(clr_flags),
    .cout(cout), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic l, input logic ud,
                               input logic s, input logic [3:0] st, input logic [7:0] mx,
                               input logic [7:0] ci, input logic cl);
    rst = r; en = e; load = l; up_down = ud; sat = s;
    step = st; max_val = mx; cin = ci; clr_flags = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] ec, input logic et,
                             input logic eo, input logic eu);
    n_checks++;
    assert (cout === ec) else begin
      n_fail++;
      $error("[TB] FAIL %s cout: observed %0d expected %0d", tag, cout, ec);
    end
    n_checks++;
    assert (tc === et) else begin
      n_fail++;
      $error("[TB] FAIL %s tc: observed %b expected %b", tag, tc, et);
    end
    n_checks++;
    assert (ovf === (eo & FLAGS)) else begin
      n_fail++;
      $error("[TB] FAIL %s ovf: observed %b expected %b", tag, ovf, eo & FLAGS);
    end
    n_checks++;
    assert (unf === (eu & FLAGS)) else begin
      n_fail++;
      $error("[TB] FAIL %s unf: observed %b expected %b", tag, unf, eu & FLAGS);
    end
  endtask

  initial begin
    $display("[TB] start, sticky flags enabled = %0d", FLAGS);
    //            rst en ld ud sat step max  cin  clr
    applyStimulus(1, 0, 0, 1, 0, 4'd0, 8'd0, 8'd0, 0);
    checkOutput("reset", 8'd0, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, 1, 4'd5, 8'd100, 8'd99, 0);
    checkOutput("load99", 8'd99, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 1, 4'd5, 8'd100, 8'd0, 0);
    checkOutput("sat_up100", 8'd100, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 1, 4'd5, 8'd100, 8'd37, 0);
    checkOutput("load37", 8'd37, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 4'd5, 8'd100, 8'd0, 0);
    checkOutput("rst_clears", 8'd0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 4'd5, 8'd100, 8'd50, 1);
    checkOutput("rst_overrides", 8'd0, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, 0, 4'd3, 8'd9, 8'd8, 0);
    checkOutput("load8", 8'd8, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd3, 8'd9, 8'd0, 0);
    checkOutput("up_wrap", 8'd1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd3, 8'd9, 8'd0, 0);
    checkOutput("up_plain", 8'd4, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd7, 8'd9, 8'd0, 1);
    checkOutput("set_beats_clr", 8'd1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 4'd7, 8'd9, 8'd0, 1);
    checkOutput("clr_en_low", 8'd1, 0, 0, 0);

    applyStimulus(0, 1, 1, 0, 1, 4'd5, 8'd9, 8'd2, 0);
    checkOutput("load2", 8'd2, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 4'd5, 8'd9, 8'd0, 0);
    checkOutput("down_sat", 8'd0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 4'd5, 8'd9, 8'd0, 0);
    checkOutput("down_sat_again", 8'd0, 1, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 4'd5, 8'd9, 8'd3, 0);
    checkOutput("load3", 8'd3, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 4'd5, 8'd9, 8'd0, 0);
    checkOutput("down_wrap", 8'd8, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 4'd2, 8'd9, 8'd0, 0);
    checkOutput("down_plain", 8'd6, 0, 0, 1);

    applyStimulus(0, 1, 1, 1, 0, 4'd0, 8'd9, 8'd200, 0);
    checkOutput("load_clamp", 8'd9, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 4'd0, 8'd9, 8'd3, 0);
    checkOutput("load_en_low", 8'd9, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 8'd9, 8'd0, 0);
    checkOutput("step_zero", 8'd9, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 4'd1, 8'd5, 8'd0, 0);
    checkOutput("bound_lowered", 8'd5, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 4'd2, 8'd5, 8'd0, 0);
    checkOutput("up_sat_at_max", 8'd5, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 4'd2, 8'd5, 8'd0, 1);
    checkOutput("clr_both", 8'd5, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, 0, 4'd3, 8'd0, 8'd7, 0);
    checkOutput("max0_load", 8'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd3, 8'd0, 8'd0, 0);
    checkOutput("max0_count", 8'd0, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, 0, 4'd15, 8'd2, 8'd0, 0);
    checkOutput("load0_max2", 8'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd15, 8'd2, 8'd0, 0);
    checkOutput("step_clamped", 8'd2, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd15, 8'd2, 8'd0, 0);
    checkOutput("step_clamped_wrap", 8'd1, 1, 1, 0);

    applyStimulus(1, 1, 0, 1, 0, 4'd1, 8'd9, 8'd0, 0);
    checkOutput("rst_mid_count", 8'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd1, 8'd9, 8'd0, 0);
    checkOutput("resume_from0", 8'd1, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, 0, 4'd15, 8'd255, 8'd250, 0);
    checkOutput("load250", 8'd250, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd15, 8'd255, 8'd0, 0);
    checkOutput("wide_up_wrap", 8'd9, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'd15, 8'd255, 8'd0, 0);
    checkOutput("wide_down_wrap", 8'd250, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
